paddle_timer: RTL
=================

Name: paddle_timer

Overview:
- Digital replacement for the paddle-pot 555 monostable.
- Falling edge of PAD_EN_N samples the active player's paddle position, then drives PAD_OUT high for a position-proportional time.
- PAD_OUT feeds the paddle video/counter stage, which ANDs it with PAD_EN_N to gate the paddle-position counter.
- Position comes from the MiSTer analog/mouse front end, one 8-bit value per player.

Parameters:
- CNT_W, 16, width of the duration counter.
- MIN_TICKS, 16'd64, pulse length in ticks at position 0.
- STEP_TICKS, 16'd4, extra ticks per position LSB.

Ports:
- CLK_DRV  in  1  system clock; all logic synchronous to it.
- RESET_N  in  1  asynchronous active-low reset.
- TICK_EN  in  1  one-cycle timebase enable; the counter decrements only when it is high.
- PAD_EN_N  in  1  trigger, active low; CLK_DRV-synchronous.
- PLAYER2  in  1  selects the position source at trigger time: 0 = P1, 1 = P2.
- POS_P1  in  8  player-1 paddle position, 0 = leftmost.
- POS_P2  in  8  player-2 paddle position.
- PAD_OUT  out  1  monostable output.
- POS_LATCHED  out  8  position captured at the last trigger.
- BUSY  out  1  high when state is not IDLE.

Behaviour:
- Reset is asynchronous and active-low on RESET_N. Reset values: state IDLE, PAD_OUT 0, BUSY 0, POS_LATCHED 0, counter 0, en_prev 0.
- en_prev resets to 0, so a PAD_EN_N already low at reset release does not trigger. PAD_EN_N must first be seen high.
- Trigger condition: en_prev==1 && PAD_EN_N==0, detected on clock edge n.
- On a trigger in IDLE, at edge n:
  - POS_LATCHED <= selected position.
  - counter <= D, where D = MIN_TICKS + POS*STEP_TICKS.
  - PAD_OUT <= 1 and BUSY <= 1, both visible after edge n (one-cycle latency).
  - Next state: TIMING, or STRETCH if D==0.
- Arithmetic for D: computed at CNT_W+8 bits, saturated to 2^CNT_W-1. No wrap.
- States:
  - IDLE: PAD_OUT 0. Waits for a trigger.
  - TIMING: PAD_OUT 1. Each cycle with TICK_EN high, counter -= 1. When the decrement brings the counter to 0:
    - if PAD_EN_N==1, go to IDLE and PAD_OUT <= 0 on that edge;
    - else go to STRETCH.
  - STRETCH: PAD_OUT 1 while PAD_EN_N is held low (555 held-trigger behaviour). Leaves on the first cycle PAD_EN_N==1: next state IDLE, PAD_OUT <= 0.
- Pulse width with PAD_EN_N released early is exactly D TICK_EN pulses, counted from the cycle after the trigger. TICK_EN in the trigger cycle is not counted.
- Retrigger while in TIMING or STRETCH is ignored. POS_LATCHED and the counter are unchanged.
- PLAYER2 and POS_P1/POS_P2 are sampled only at the trigger edge. Changes mid-pulse have no effect.
- BUSY = (state != IDLE), registered alongside the state.
- Trigger on the same edge that returns the FSM to IDLE is ignored. This cannot occur in normal operation because exit requires PAD_EN_N high.

Decomposition:
- Package paddle_pkg holds:
  - typedef enum {PT_IDLE, PT_TIMING, PT_STRETCH} pt_state_t;
  - localparam POS_W = 8.
- One sub-module, edge_fall_det (registered falling-edge detector with reset value parameter), reused by other trigger inputs.
- Duration multiply/saturate stays inline.

Test Plan:
- Basic timing (MIN=8, STEP=2, TICK_EN=1, POS_P1=10, PLAYER2=0): PAD_EN_N low for 4 cycles -> PAD_OUT high for 28 cycles starting the cycle after the trigger edge; POS_LATCHED=10; BUSY tracks PAD_OUT.
- Held trigger (same parameters, POS=0): PAD_EN_N low for 20 cycles -> PAD_OUT stays high until the cycle after PAD_EN_N rises (20 cycles, STRETCH entered after 8).
- Player select and sample-hold: PLAYER2=1, POS_P2=3, POS_P1=200; change POS_P2 to 99 mid-pulse -> POS_LATCHED=3, width 14.
- TICK_EN every 4th cycle, D=28 -> pulse spans 28 enables, about 112 clocks. A second PAD_EN_N pulse mid-TIMING is ignored and the width is unchanged.
- Saturation (CNT_W=8, MIN=200, STEP=4, POS=255) -> counter loads 255 and the pulse is 255 ticks.
- Reset cases:
  - Assert RESET_N low mid-TIMING -> PAD_OUT, BUSY, POS_LATCHED go to 0 immediately, with no clock edge.
  - Release reset with PAD_EN_N low -> no pulse until PAD_EN_N rises and falls again.

Source files
------------

// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared types and constants for the paddle monostable
package paddle_pkg;

  // Width of one player's paddle position sample.
  localparam int POS_W = 8;

  // Monostable states: waiting, counting down, held by a low trigger.
  typedef enum logic [1:0] {
    PT_IDLE    = 2'd0,
    PT_TIMING  = 2'd1,
    PT_STRETCH = 2'd2
  } pt_state_t;

endpackage

// File: rtl/edge_fall_det.sv
// rtl/edge_fall_det.sv - registered falling-edge detector with configurable reset level
module edge_fall_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_fall
);

  logic r_prev;

  // Remember last cycle's level; resetting to 0 means a line already low
  // at reset release must be seen high before it can produce an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= RESET_VAL;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_fall = r_prev & ~i_sig;

endmodule

// File: rtl/paddle_timer.sv
// rtl/paddle_timer.sv - digital paddle-pot monostable with position-proportional pulse
module paddle_timer
  import paddle_pkg::*;
#(
  parameter int             CNT_W      = 16,
  parameter logic [CNT_W-1:0] MIN_TICKS  = 16'd64,
  parameter logic [CNT_W-1:0] STEP_TICKS = 16'd4
) (
  input  logic             CLK_DRV,
  input  logic             RESET_N,
  input  logic             TICK_EN,
  input  logic             PAD_EN_N,
  input  logic             PLAYER2,
  input  logic [POS_W-1:0] POS_P1,
  input  logic [POS_W-1:0] POS_P2,
  output logic             PAD_OUT,
  output logic [POS_W-1:0] POS_LATCHED,
  output logic             BUSY
);

  // Duration math is done wide enough that MIN + 255*STEP can never wrap.
  localparam int DW = CNT_W + POS_W;

  pt_state_t          r_state;
  pt_state_t          w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [POS_W-1:0]   r_pos;
  logic               r_pad_out;
  logic               r_busy;

  logic               w_trig;
  logic [POS_W-1:0]   w_pos_sel;
  logic [DW-1:0]      w_dur_wide;
  logic [CNT_W-1:0]   w_dur;
  logic               w_load;
  logic               w_dec;

  // Trigger is a high-to-low transition of the active-low enable.
  edge_fall_det #(
    .RESET_VAL (1'b0)
  ) u_trig_det (
    .i_clk   (CLK_DRV),
    .i_rst_n (RESET_N),
    .i_sig   (PAD_EN_N),
    .o_fall  (w_trig)
  );

  assign w_pos_sel  = PLAYER2 ? POS_P2 : POS_P1;
  assign w_dur_wide = DW'(MIN_TICKS) + (DW'(w_pos_sel) * DW'(STEP_TICKS));
  // Clamp to the largest count the duration counter can hold.
  assign w_dur      = (|w_dur_wide[DW-1:CNT_W]) ? {CNT_W{1'b1}} : w_dur_wide[CNT_W-1:0];

  // Next-state and datapath control; triggers outside IDLE are ignored.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      PT_IDLE: begin
        if (w_trig) begin
          w_load       = 1'b1;
          w_state_next = (w_dur == '0) ? PT_STRETCH : PT_TIMING;
        end
      end
      PT_TIMING: begin
        if (TICK_EN && (r_cnt != '0)) begin
          w_dec = 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = PAD_EN_N ? PT_IDLE : PT_STRETCH;
          end
        end
      end
      PT_STRETCH: begin
        if (PAD_EN_N) begin
          w_state_next = PT_IDLE;
        end
      end
      default: begin
        w_state_next = PT_IDLE;
      end
    endcase
  end

  // State register with registered output and busy flag derived from next state.
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= PT_IDLE;
      r_pad_out <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pad_out <= (w_state_next != PT_IDLE);
      r_busy    <= (w_state_next != PT_IDLE);
    end
  end

  // Position latch and duration counter; only loaded on an accepted trigger.
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
      r_pos <= '0;
    end else if (w_load) begin
      r_cnt <= w_dur;
      r_pos <= w_pos_sel;
    end else if (w_dec) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign PAD_OUT     = r_pad_out;
  assign BUSY        = r_busy;
  assign POS_LATCHED = r_pos;

endmodule
